// File: rtl/ysyx_22041211_lsu_pkg.sv
// Shared encodings for the load/store unit:
// load/store type codes and FSM state codes.
package ysyx_22041211_lsu_pkg;

   localparam logic [2:0] LOAD_NONE = 3'd0;
   localparam logic [2:0] LOAD_LB   = 3'd1;
   localparam logic [2:0] LOAD_LH   = 3'd2;
   localparam logic [2:0] LOAD_LW   = 3'd3;
   localparam logic [2:0] LOAD_LBU  = 3'd4;
   localparam logic [2:0] LOAD_LHU  = 3'd5;

   localparam logic [1:0] STORE_NONE = 2'd0;
   localparam logic [1:0] STORE_SB   = 2'd1;
   localparam logic [1:0] STORE_SH   = 2'd2;
   localparam logic [1:0] STORE_SW   = 2'd3;

   localparam logic [1:0] LSU_IDLE     = 2'd0;
   localparam logic [1:0] LSU_REQ      = 2'd1;
   localparam logic [1:0] LSU_RESP     = 2'd2;
   localparam logic [1:0] LSU_WB_VALID = 2'd3;

   // Reserved load codes and load+store combos
   // collapse to "no load"; the store wins.
   function automatic logic [2:0] eff_load(
      input logic [2:0] ld,
      input logic [1:0] st
   );
      if (st != STORE_NONE || ld > LOAD_LHU)
         return LOAD_NONE;
      return ld;
   endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// Byte-lane steering for the LSU: store shift
// and strobes, load extract/extend, misalign.
module ysyx_22041211_lsu_align
   import ysyx_22041211_lsu_pkg::*;
(
   input  logic [2:0]  i_load_type,
   input  logic [1:0]  i_store_type,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic        o_is_load,
   output logic        o_is_store,
   output logic        o_misalign,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata_ext
);

   logic [2:0]  w_ld;
   logic        w_half;
   logic        w_word;
   logic [31:0] w_bshift;
   logic [31:0] w_hshift;
   logic [7:0]  w_byte;
   logic [15:0] w_half_d;

   assign w_ld       = eff_load(i_load_type, i_store_type);
   assign o_is_load  = (w_ld != LOAD_NONE);
   assign o_is_store = (i_store_type != STORE_NONE);

   // Halfword needs even address, word needs 4-aligned.
   always_comb begin
      w_half = (w_ld == LOAD_LH) || (w_ld == LOAD_LHU) ||
               (i_store_type == STORE_SH);
      w_word = (w_ld == LOAD_LW) || (i_store_type == STORE_SW);
      o_misalign = (w_half & i_addr_lo[0]) |
                   (w_word & (i_addr_lo != 2'b00));
   end

   // Replicate store data across lanes; strobe picks the lane.
   always_comb begin
      o_wstrb = 4'b0000;
      o_wdata = i_wdata;
      case (i_store_type)
         STORE_SB: begin
            o_wstrb = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
         end
         STORE_SH: begin
            o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_wdata[15:0]}};
         end
         STORE_SW: o_wstrb = 4'b1111;
         default:  o_wstrb = 4'b0000;
      endcase
   end

   assign w_bshift = i_rdata >> {i_addr_lo, 3'b000};
   assign w_hshift = i_rdata >> {i_addr_lo[1], 4'b0000};
   assign w_byte   = w_bshift[7:0];
   assign w_half_d = w_hshift[15:0];

   // Pick the addressed byte/half and extend it.
   always_comb begin
      o_rdata_ext = i_rdata;
      case (w_ld)
         LOAD_LB:  o_rdata_ext = {{24{w_byte[7]}}, w_byte};
         LOAD_LH:  o_rdata_ext = {{16{w_half_d[15]}}, w_half_d};
         LOAD_LBU: o_rdata_ext = {24'd0, w_byte};
         LOAD_LHU: o_rdata_ext = {16'd0, w_half_d};
         default:  o_rdata_ext = i_rdata;
      endcase
   end

endmodule

// File: rtl/ysyx_22041211_lsu.sv
// Load/store stage: captures the execute bundle, runs
// one data-memory transaction, presents a WB bundle.
module ysyx_22041211_lsu
   import ysyx_22041211_lsu_pkg::*;
#(
   parameter int DATA_LEN = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                exu_valid_i,
   output logic                lsu_ready_o,
   input  logic [2:0]          load_type_i,
   input  logic [1:0]          store_type_i,
   input  logic [DATA_LEN-1:0] alu_result_i,
   input  logic [DATA_LEN-1:0] mem_wdata_i,
   input  logic                wd_i,
   input  logic [4:0]          wreg_i,
   input  logic [DATA_LEN-1:0] csr_wdata_i,
   input  logic [DATA_LEN-1:0] csr_mcause_i,
   input  logic                branch_request_i,
   input  logic [DATA_LEN-1:0] pc_i,
   output logic                dmem_req_o,
   input  logic                dmem_gnt_i,
   output logic [DATA_LEN-1:0] dmem_addr_o,
   output logic                dmem_wen_o,
   output logic [DATA_LEN-1:0] dmem_wdata_o,
   output logic [3:0]          dmem_wstrb_o,
   input  logic                dmem_rvalid_i,
   input  logic [DATA_LEN-1:0] dmem_rdata_i,
   output logic                wb_valid_o,
   input  logic                wb_ready_i,
   output logic                wb_wd_o,
   output logic [4:0]          wb_wreg_o,
   output logic [DATA_LEN-1:0] wb_wdata_o,
   output logic [DATA_LEN-1:0] wb_csr_wdata_o,
   output logic [DATA_LEN-1:0] wb_csr_mcause_o,
   output logic                wb_branch_request_o,
   output logic [DATA_LEN-1:0] wb_pc_o,
   output logic                wb_misalign_o
);

   logic [1:0]          r_state;
   logic [2:0]          r_load;
   logic [1:0]          r_store;
   logic [DATA_LEN-1:0] r_addr;
   logic [DATA_LEN-1:0] r_mem_wdata;
   logic                r_wd;
   logic [4:0]          r_wreg;
   logic [DATA_LEN-1:0] r_csr_wdata;
   logic [DATA_LEN-1:0] r_mcause;
   logic                r_branch;
   logic [DATA_LEN-1:0] r_pc;
   logic [DATA_LEN-1:0] r_wb_wdata;
   logic                r_misalign;

   logic                w_idle;
   logic                w_req;
   logic [2:0]          w_sel_load;
   logic [1:0]          w_sel_store;
   logic [1:0]          w_sel_lo;
   logic                w_is_load;
   logic                w_is_store;
   logic                w_misalign;
   logic [3:0]          w_wstrb;
   logic [DATA_LEN-1:0] w_wdata;
   logic [DATA_LEN-1:0] w_rdata_ext;

   assign w_idle = (r_state == LSU_IDLE);
   assign w_req  = (r_state == LSU_REQ);

   // In IDLE the aligner sees the incoming bundle so the
   // misalign decision is ready at accept; later, the latch.
   assign w_sel_load  = w_idle ? load_type_i  : r_load;
   assign w_sel_store = w_idle ? store_type_i : r_store;
   assign w_sel_lo    = w_idle ? alu_result_i[1:0] : r_addr[1:0];

   ysyx_22041211_lsu_align u_align (
      .i_load_type  (w_sel_load),
      .i_store_type (w_sel_store),
      .i_addr_lo    (w_sel_lo),
      .i_wdata      (r_mem_wdata),
      .i_rdata      (dmem_rdata_i),
      .o_is_load    (w_is_load),
      .o_is_store   (w_is_store),
      .o_misalign   (w_misalign),
      .o_wstrb      (w_wstrb),
      .o_wdata      (w_wdata),
      .o_rdata_ext  (w_rdata_ext)
   );

   // FSM plus bundle capture; load data lands on rvalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= LSU_IDLE;
         r_load      <= LOAD_NONE;
         r_store     <= STORE_NONE;
         r_addr      <= '0;
         r_mem_wdata <= '0;
         r_wd        <= 1'b0;
         r_wreg      <= '0;
         r_csr_wdata <= '0;
         r_mcause    <= '0;
         r_branch    <= 1'b0;
         r_pc        <= '0;
         r_wb_wdata  <= '0;
         r_misalign  <= 1'b0;
      end else begin
         case (r_state)
            LSU_IDLE: begin
               if (exu_valid_i) begin
                  r_load      <= load_type_i;
                  r_store     <= store_type_i;
                  r_addr      <= alu_result_i;
                  r_mem_wdata <= mem_wdata_i;
                  r_wd        <= wd_i & ~w_misalign;
                  r_wreg      <= wreg_i;
                  r_csr_wdata <= csr_wdata_i;
                  r_mcause    <= csr_mcause_i;
                  r_branch    <= branch_request_i;
                  r_pc        <= pc_i;
                  r_wb_wdata  <= alu_result_i;
                  r_misalign  <= w_misalign;
                  if ((w_is_load | w_is_store) & ~w_misalign)
                     r_state <= LSU_REQ;
                  else
                     r_state <= LSU_WB_VALID;
               end
            end
            LSU_REQ: begin
               if (dmem_gnt_i) begin
                  if (dmem_rvalid_i) begin
                     r_state <= LSU_WB_VALID;
                     if (w_is_load)
                        r_wb_wdata <= w_rdata_ext;
                  end else begin
                     r_state <= LSU_RESP;
                  end
               end
            end
            LSU_RESP: begin
               if (dmem_rvalid_i) begin
                  r_state <= LSU_WB_VALID;
                  if (w_is_load)
                     r_wb_wdata <= w_rdata_ext;
               end
            end
            LSU_WB_VALID: begin
               if (wb_ready_i)
                  r_state <= LSU_IDLE;
            end
            default: r_state <= LSU_IDLE;
         endcase
      end
   end

   assign lsu_ready_o  = w_idle;
   assign dmem_req_o   = w_req;
   assign dmem_addr_o  = {r_addr[DATA_LEN-1:2], 2'b00};
   assign dmem_wen_o   = w_req & w_is_store;
   assign dmem_wstrb_o = w_req ? w_wstrb : 4'b0000;
   assign dmem_wdata_o = w_req ? w_wdata : '0;

   assign wb_valid_o          = (r_state == LSU_WB_VALID);
   assign wb_wd_o             = r_wd;
   assign wb_wreg_o           = r_wreg;
   assign wb_wdata_o          = r_wb_wdata;
   assign wb_csr_wdata_o      = r_csr_wdata;
   assign wb_csr_mcause_o     = r_mcause;
   assign wb_branch_request_o = r_branch;
   assign wb_pc_o             = r_pc;
   assign wb_misalign_o       = r_misalign;

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Self-checking bench for ysyx_22041211_lsu:
// transaction-level model, per-cycle compare.
module tb_ysyx_22041211_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        exu_valid_i;
   logic        lsu_ready_o;
   logic [2:0]  load_type_i;
   logic [1:0]  store_type_i;
   logic [31:0] alu_result_i;
   logic [31:0] mem_wdata_i;
   logic        wd_i;
   logic [4:0]  wreg_i;
   logic [31:0] csr_wdata_i;
   logic [31:0] csr_mcause_i;
   logic        branch_request_i;
   logic [31:0] pc_i;
   logic        dmem_req_o;
   logic        dmem_gnt_i;
   logic [31:0] dmem_addr_o;
   logic        dmem_wen_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_wstrb_o;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        wb_valid_o;
   logic        wb_ready_i;
   logic        wb_wd_o;
   logic [4:0]  wb_wreg_o;
   logic [31:0] wb_wdata_o;
   logic [31:0] wb_csr_wdata_o;
   logic [31:0] wb_csr_mcause_o;
   logic        wb_branch_request_o;
   logic [31:0] wb_pc_o;
   logic        wb_misalign_o;

   always #5 clk = ~clk;

   ysyx_22041211_lsu #(.DATA_LEN(32)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .exu_valid_i         (exu_valid_i),
      .lsu_ready_o         (lsu_ready_o),
      .load_type_i         (load_type_i),
      .store_type_i        (store_type_i),
      .alu_result_i        (alu_result_i),
      .mem_wdata_i         (mem_wdata_i),
      .wd_i                (wd_i),
      .wreg_i              (wreg_i),
      .csr_wdata_i         (csr_wdata_i),
      .csr_mcause_i        (csr_mcause_i),
      .branch_request_i    (branch_request_i),
      .pc_i                (pc_i),
      .dmem_req_o          (dmem_req_o),
      .dmem_gnt_i          (dmem_gnt_i),
      .dmem_addr_o         (dmem_addr_o),
      .dmem_wen_o          (dmem_wen_o),
      .dmem_wdata_o        (dmem_wdata_o),
      .dmem_wstrb_o        (dmem_wstrb_o),
      .dmem_rvalid_i       (dmem_rvalid_i),
      .dmem_rdata_i        (dmem_rdata_i),
      .wb_valid_o          (wb_valid_o),
      .wb_ready_i          (wb_ready_i),
      .wb_wd_o             (wb_wd_o),
      .wb_wreg_o           (wb_wreg_o),
      .wb_wdata_o          (wb_wdata_o),
      .wb_csr_wdata_o      (wb_csr_wdata_o),
      .wb_csr_mcause_o     (wb_csr_mcause_o),
      .wb_branch_request_o (wb_branch_request_o),
      .wb_pc_o             (wb_pc_o),
      .wb_misalign_o       (wb_misalign_o)
   );

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // ---- model: access size/alignment arithmetic ----
   function automatic int f_size(logic [2:0] ld, logic [1:0] st);
      if (st == 2'd1) return 1;
      if (st == 2'd2) return 2;
      if (st == 2'd3) return 4;
      case (ld)
         3'd1, 3'd4: return 1;
         3'd2, 3'd5: return 2;
         3'd3:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic bit f_mis(logic [2:0] ld, logic [1:0] st,
                                logic [31:0] a);
      int sz = f_size(ld, st);
      return (sz > 1) && ((int'(a[1:0]) % sz) != 0);
   endfunction

   function automatic logic [31:0] f_mask(int sz);
      if (sz >= 4) return 32'hFFFF_FFFF;
      return (32'h1 << (8 * sz)) - 32'h1;
   endfunction

   function automatic logic [3:0] f_strb(logic [1:0] st,
                                         logic [31:0] a);
      int sz = f_size(3'd0, st);
      logic [7:0] s;
      if (st == 2'd0) return 4'b0000;
      s = 8'(((1 << sz) - 1) << int'(a[1:0]));
      return s[3:0];
   endfunction

   function automatic logic [31:0] f_bus(logic [1:0] st,
                                         logic [31:0] d);
      if (st == 2'd1) return {24'd0, d[7:0]} * 32'h0101_0101;
      if (st == 2'd2) return {16'd0, d[15:0]} * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] f_load(logic [2:0] ld,
                                          logic [31:0] a,
                                          logic [31:0] rd);
      int sz = f_size(ld, 2'd0);
      logic [31:0] m = f_mask(sz);
      logic [31:0] v = (rd >> (8 * int'(a[1:0]))) & m;
      if ((ld == 3'd1 || ld == 3'd2) && v[8 * sz - 1])
         v = v | ~m;
      return v;
   endfunction

   // model state: the bundle of the in-flight transaction
   bit          m_busy = 1'b0;
   logic [2:0]  m_ld;
   logic [1:0]  m_st;
   logic [31:0] m_addr, m_sdata, m_rdata;
   bit          m_wd, m_br, m_mem, m_mis;
   logic [4:0]  m_wreg;
   logic [31:0] m_csr, m_mc, m_pc;
   logic [31:0] cur_rdata = 32'd0;

   // model tracks acceptance and the WB handshake
   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0;
      end else if (!m_busy && exu_valid_i) begin
         m_busy  = 1'b1;
         m_st    = store_type_i;
         m_ld    = (store_type_i != 0 || load_type_i > 5)
                   ? 3'd0 : load_type_i;
         m_addr  = alu_result_i;
         m_sdata = mem_wdata_i;
         m_rdata = cur_rdata;
         m_mem   = f_size(m_ld, m_st) > 0;
         m_mis   = f_mis(m_ld, m_st, m_addr);
         m_wd    = wd_i && !m_mis;
         m_wreg  = wreg_i;
         m_csr   = csr_wdata_i;
         m_mc    = csr_mcause_i;
         m_br    = branch_request_i;
         m_pc    = pc_i;
      end else if (m_busy && wb_valid_o && wb_ready_i) begin
         m_busy = 1'b0;
      end
   end

   // compare DUT against the model every cycle
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("lsu_ready", 32'(lsu_ready_o), 32'(!m_busy));
         if (!m_busy) begin
            chk("idle_req", 32'(dmem_req_o), 32'd0);
            chk("idle_wbv", 32'(wb_valid_o), 32'd0);
         end
         if (dmem_req_o) begin
            chk("req_allowed", 32'(m_busy && m_mem && !m_mis), 1);
            chk("req_addr", dmem_addr_o, m_addr & ~32'd3);
            chk("req_wen", 32'(dmem_wen_o), 32'(m_st != 0));
            chk("req_wstrb", 32'(dmem_wstrb_o), 32'(f_strb(m_st, m_addr)));
            if (m_st != 0)
               chk("req_wdata", dmem_wdata_o, f_bus(m_st, m_sdata));
         end
         if (wb_valid_o && m_busy) begin
            chk("wb_wd", 32'(wb_wd_o), 32'(m_wd));
            chk("wb_wreg", 32'(wb_wreg_o), 32'(m_wreg));
            chk("wb_wdata", wb_wdata_o,
                (m_ld != 0 && !m_mis)
                ? f_load(m_ld, m_addr, m_rdata) : m_addr);
            chk("wb_csr", wb_csr_wdata_o, m_csr);
            chk("wb_mcause", wb_csr_mcause_o, m_mc);
            chk("wb_branch", 32'(wb_branch_request_o), 32'(m_br));
            chk("wb_pc", wb_pc_o, m_pc);
            chk("wb_misalign", 32'(wb_misalign_o), 32'(m_mis));
         end
      end
   end

   // hand-computed literal expectations for single runs
   bit          lit_wb_en = 0, lit_mis_en = 0, lit_req_en = 0;
   logic [31:0] lit_wb, lit_addr, lit_wdata;
   logic [3:0]  lit_strb;

   task automatic run(input logic [2:0] ld, input logic [1:0] st,
                      input logic [31:0] addr, input logic [31:0] sd,
                      input logic [31:0] rd, input logic [4:0] wreg,
                      input int gd, input int rvd, input int yd,
                      input int lat);
      int k = 0, rq = 0, rvc = 0, wc = 0;
      bit granted = 0, resp = 0, seen = 0, done = 0;
      @(posedge clk); #1;
      load_type_i      = ld;
      store_type_i     = st;
      alu_result_i     = addr;
      mem_wdata_i      = sd;
      wd_i             = 1'b1;
      wreg_i           = wreg;
      csr_wdata_i      = 32'hC500_0000 ^ addr;
      csr_mcause_i     = {27'd0, wreg} + 32'd7;
      branch_request_i = wreg[0];
      pc_i             = 32'h8000_1000 + {27'd0, wreg, 2'b00};
      cur_rdata        = rd;
      dmem_rdata_i     = rd;
      exu_valid_i      = 1'b1;
      wb_ready_i       = 1'b0;
      while (!done && k < 60) begin
         @(posedge clk); #1;
         k++;
         if (k == 1) begin
            exu_valid_i  = 1'b0;
            load_type_i  = 3'd3;
            store_type_i = 2'd1;
            alu_result_i = ~addr;
            mem_wdata_i  = ~sd;
            wreg_i       = ~wreg;
            pc_i         = 32'hDEAD_0000;
            csr_wdata_i  = 32'h0;
         end
         dmem_gnt_i    = 1'b0;
         dmem_rvalid_i = 1'b0;
         wb_ready_i    = 1'b0;
         if (wb_valid_o) begin
            if (!seen) begin
               seen = 1;
               if (lat > 0) chk("latency", k, lat);
               if (lit_wb_en) chk("lit_wb_wdata", wb_wdata_o, lit_wb);
               if (lit_mis_en) begin
                  chk("lit_misalign", 32'(wb_misalign_o), 1);
                  chk("lit_wd", 32'(wb_wd_o), 0);
               end
            end
            if (wc >= yd) begin
               wb_ready_i = 1'b1;
               done = 1;
            end
            wc++;
         end else if (dmem_req_o && !granted) begin
            if (rq == 0 && lit_req_en) begin
               chk("lit_addr", dmem_addr_o, lit_addr);
               chk("lit_wstrb", 32'(dmem_wstrb_o), 32'(lit_strb));
               chk("lit_wdata", dmem_wdata_o, lit_wdata);
               chk("lit_wen", 32'(dmem_wen_o), 1);
            end
            if (rq == gd) begin
               dmem_gnt_i = 1'b1;
               granted = 1;
               if (rvd == 0) begin
                  dmem_rvalid_i = 1'b1;
                  resp = 1;
               end
            end
            rq++;
         end else if (granted && !resp) begin
            rvc++;
            if (rvc >= rvd) begin
               dmem_rvalid_i = 1'b1;
               resp = 1;
            end
         end
      end
      if (!done) chk("timeout", 0, 1);
      lit_wb_en = 0; lit_mis_en = 0; lit_req_en = 0;
   endtask

   initial begin
      rst = 1'b1;
      exu_valid_i = 0; load_type_i = 0; store_type_i = 0;
      alu_result_i = 0; mem_wdata_i = 0; wd_i = 0; wreg_i = 0;
      csr_wdata_i = 0; csr_mcause_i = 0; branch_request_i = 0;
      pc_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0;
      dmem_rdata_i = 0; wb_ready_i = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cmp_on = 1'b1;
      chk("rst_ready", 32'(lsu_ready_o), 1);
      chk("rst_req", 32'(dmem_req_o), 0);
      chk("rst_wbv", 32'(wb_valid_o), 0);
      chk("rst_mis", 32'(wb_misalign_o), 0);
      chk("rst_wdata", wb_wdata_o, 0);
      chk("rst_addr", dmem_addr_o, 0);

      lit_wb_en = 1; lit_wb = 32'h0000_1234;
      run(3'd0, 2'd0, 32'h1234, 32'h0, 32'h0, 5'd5, 0, 0, 0, 1);
      lit_wb_en = 1; lit_wb = 32'hFFFF_FF80;
      run(3'd1, 2'd0, 32'h8000_0003, 0, 32'h80FF_1122, 5'd6, 0, 0, 0, 2);
      lit_wb_en = 1; lit_wb = 32'h0000_0080;
      run(3'd4, 2'd0, 32'h8000_0003, 0, 32'h80FF_1122, 5'd7, 0, 0, 0, 2);
      lit_req_en = 1; lit_addr = 32'h8000_0000;
      lit_strb = 4'b1100; lit_wdata = 32'hABCD_ABCD;
      run(3'd0, 2'd2, 32'h8000_0002, 32'h1234_ABCD, 0, 5'd8, 0, 0, 0, 2);
      lit_mis_en = 1;
      run(3'd3, 2'd0, 32'h8000_0001, 0, 32'h1111_2222, 5'd9, 0, 0, 0, 1);
      run(3'd0, 2'd3, 32'h8000_0010, 32'hDEAD_BEEF, 0, 5'd10, 3, 1, 4, 0);
      lit_wb_en = 1; lit_wb = 32'hFFFF_8001;
      run(3'd2, 2'd0, 32'h8000_0002, 0, 32'h8001_7FFF, 5'd11, 0, 2, 1, 0);
      lit_wb_en = 1; lit_wb = 32'h0000_F00D;
      run(3'd5, 2'd0, 32'h8000_0000, 0, 32'h1234_F00D, 5'd12, 0, 0, 0, 2);
      run(3'd3, 2'd0, 32'h8000_0004, 0, 32'hCAFE_BABE, 5'd13, 1, 0, 0, 0);
      lit_req_en = 1; lit_addr = 32'h8000_0000;
      lit_strb = 4'b0010; lit_wdata = 32'h7777_7777;
      run(3'd0, 2'd1, 32'h8000_0001, 32'h55AA_0077, 0, 5'd14, 0, 0, 0, 2);
      lit_mis_en = 1;
      run(3'd0, 2'd2, 32'h8000_0003, 32'h1, 0, 5'd15, 0, 0, 0, 1);
      run(3'd2, 2'd0, 32'h8000_0001, 0, 32'h5, 5'd16, 0, 0, 0, 1);
      run(3'd6, 2'd0, 32'h8000_0001, 0, 32'h5, 5'd17, 0, 0, 0, 1);
      run(3'd1, 2'd3, 32'h8000_0008, 32'h0102_0304, 32'hFF, 5'd18, 0, 0, 1, 2);

      // reset while waiting in RESP
      @(posedge clk); #1;
      wb_ready_i = 0;
      load_type_i = 3'd3; store_type_i = 0;
      alu_result_i = 32'h8000_0020; exu_valid_i = 1;
      @(posedge clk); #1;
      exu_valid_i = 0;
      chk("rstx_req", 32'(dmem_req_o), 1);
      dmem_gnt_i = 1;
      @(posedge clk); #1;
      dmem_gnt_i = 0;
      chk("rstx_busy", 32'(lsu_ready_o), 0);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("rstx_ready", 32'(lsu_ready_o), 1);
      chk("rstx_wbv", 32'(wb_valid_o), 0);
      dmem_rvalid_i = 1;
      @(posedge clk); #1;
      dmem_rvalid_i = 0;
      chk("stray_wbv", 32'(wb_valid_o), 0);
      chk("stray_ready", 32'(lsu_ready_o), 1);
      repeat (2) @(posedge clk);
      #1;
      chk("stray_wbv2", 32'(wb_valid_o), 0);

      lit_wb_en = 1; lit_wb = 32'h0000_00AB;
      run(3'd0, 2'd0, 32'hAB, 0, 0, 5'd3, 0, 0, 0, 1);
      @(posedge clk); #1;
      wb_ready_i = 0;
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_22041211_lsu.md
Name: ysyx_22041211_lsu

Overview:
- Load/store stage directly downstream of the execute stage.
- Captures the execute result bundle on a valid/ready handshake.
- For loads and stores, issues one transaction on a simple request/response data-memory bus. Loads are sign- or zero-extended. Stores are byte-lane aligned with a write strobe.
- Presents a registered write-back bundle to the WB stage under a valid/ready handshake. Non-memory instructions pass through in fixed latency.

Parameters:
- DATA_LEN, 32, datapath and address width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- exu_valid_i  in  1  execute bundle valid
- lsu_ready_o  out  1  LSU can accept a bundle
- load_type_i  in  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU
- store_type_i  in  2  0 none, 1 SB, 2 SH, 3 SW
- alu_result_i  in  32  effective address, or ALU result for non-memory instructions
- mem_wdata_i  in  32  store data, unshifted
- wd_i  in  1  register write enable
- wreg_i  in  5  destination register
- csr_wdata_i  in  32  CSR write data, pass-through
- csr_mcause_i  in  32  mcause, pass-through
- branch_request_i  in  1  pass-through
- pc_i  in  32  pass-through
- dmem_req_o  out  1  bus request valid
- dmem_gnt_i  in  1  bus accepts request
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wen_o  out  1  1 = write
- dmem_wdata_o  out  32  lane-shifted store data
- dmem_wstrb_o  out  4  byte strobes
- dmem_rvalid_i  in  1  response valid (reads and writes)
- dmem_rdata_i  in  32  read word
- wb_valid_o  out  1  write-back bundle valid
- wb_ready_i  in  1  WB accepts
- wb_wd_o  out  1  write enable; forced 0 when misaligned
- wb_wreg_o  out  5  destination register
- wb_wdata_o  out  32  extended load data, or alu_result for non-loads
- wb_csr_wdata_o  out  32  pass-through
- wb_csr_mcause_o  out  32  pass-through
- wb_branch_request_o  out  1  pass-through
- wb_pc_o  out  32  pass-through
- wb_misalign_o  out  1  misaligned load/store detected

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset:
  - state = IDLE
  - dmem_req_o = 0, wb_valid_o = 0, wb_misalign_o = 0
  - all other registered outputs = 0
- Reset mid-transaction drops any outstanding bus transaction. Any late dmem_rvalid_i is ignored while in IDLE.
- lsu_ready_o = (state == IDLE). It is combinational from state.
- Accept happens in IDLE when exu_valid_i = 1. All inputs are latched that cycle. exu_valid_i may be a 1-cycle pulse.
- Misalignment:
  - Halfword: addr[0] = 1.
  - Word: addr[1:0] != 0.
  - A misaligned access issues no bus request and goes straight to WB_VALID with wb_misalign_o = 1 and wb_wd_o = 0.
- States:
  - IDLE: accept. If load/store and aligned, go to REQ; otherwise go to WB_VALID.
  - REQ: dmem_req_o = 1 with stable addr/wen/wdata/wstrb until dmem_gnt_i. On gnt go to RESP. If dmem_rvalid_i arrives in the same cycle as gnt, go directly to WB_VALID.
  - RESP: wait for dmem_rvalid_i, then go to WB_VALID. For loads, the extended data is registered into wb_wdata_o.
  - WB_VALID: wb_valid_o = 1 with all wb_* stable. On wb_ready_i go to IDLE.
- Latency:
  - Non-memory instruction: wb_valid_o rises 1 cycle after accept.
  - Memory access with gnt and rvalid both in the first REQ cycle: wb_valid_o rises 2 cycles after accept.
- Stores:
  - SB: wstrb = 1 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111.
- Loads: byte/half are selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. For loads, dmem_wstrb_o = 0.
- Reserved encodings: load_type 6/7 are treated as none. If load and store are both nonzero, the store wins.

Decomposition:
- Shared define file: LOAD_*/STORE_* encodings and LSU state encodings.
- One sub-module, ysyx_22041211_lsu_align, combinational:
  - store lane shift + strobe generation
  - load extract/extend
  - misalign detect

Test Plan:
- Non-memory: accept alu_result = 0x1234, wd = 1, wreg = 5, wb_ready = 1 -> wb_valid 1 cycle later with wb_wdata = 0x1234; no dmem_req.
- LB sign-extend: addr 0x80000003, rdata 0x80FF1122, gnt and rvalid 1 cycle later -> wb_wdata = 0xFFFFFF80; LBU gives 0x00000080.
- SH at 0x80000002, data 0xABCD -> dmem_addr = 0x80000000, wstrb = 1100, wdata = 0xABCDABCD, wen = 1.
- LW at 0x80000001 -> no dmem_req, wb_misalign = 1, wb_wd = 0.
- Backpressure: gnt delayed 3 cycles and wb_ready low 4 cycles -> request signals and wb bundle held stable; lsu_ready = 0 until the WB handshake.
- rst asserted in RESP -> next cycle IDLE, lsu_ready = 1, wb_valid = 0; a stray rvalid afterwards has no effect.
